// File: rtl/imem_fetch_responder.sv
// Instruction-fetch responder: fixed-latency, in-order instruction memory with
// request backpressure, a branch-redirect flush and a program-load write port.
module imem_fetch_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2,
  parameter int QDEPTH      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic [63:0] ReqAddr,
  output logic        RspValid,
  input  logic        RspReady,
  output logic [31:0] RspInstr,
  output logic [63:0] RspAddr,
  output logic        RspFault,
  input  logic        Flush,
  input  logic        LdEn,
  input  logic [63:0] LdAddr,
  input  logic [31:0] LdData
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic        fault;
    logic [63:0] addr;
    logic [31:0] instr;
  } entry_t;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [CW-1:0] occ;
  logic          accept;
  logic          pop;
  logic          req_fault;
  logic          ld_in_range;
  logic          unused_ld_lsb;
  entry_t        acc_entry;
  entry_t        fifo_in;
  logic          fifo_in_v;
  entry_t        fifo [QDEPTH];
  entry_t        head_e;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] fifo_cnt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign req_fault     = (ReqAddr[1:0] != 2'b00) || (ReqAddr[63:2] >= 62'(DEPTH_WORDS));
  assign ld_in_range   = (LdAddr[63:2] < 62'(DEPTH_WORDS));
  assign unused_ld_lsb = ^LdAddr[1:0];

  assign RspValid = (fifo_cnt != '0);
  assign pop      = RspValid && RspReady;
  assign ReqReady = !rst && !Flush && (occ < CW'(QDEPTH));
  assign accept   = ReqValid && ReqReady;

  // Memory is read in the accept cycle, so a same-cycle load returns the old word.
  always_comb begin
    acc_entry.fault = req_fault;
    acc_entry.addr  = ReqAddr;
    acc_entry.instr = req_fault ? NOP : mem[ReqAddr[2 +: AW]];
  end

  always_ff @(posedge clk) begin
    if (LdEn && ld_in_range) mem[LdAddr[2 +: AW]] <= LdData;
  end

  // The FIFO write itself supplies the last cycle of latency.
  if (LATENCY == 1) begin : g_nopipe
    assign fifo_in   = acc_entry;
    assign fifo_in_v = accept;
  end else begin : g_pipe
    entry_t               pipe [LATENCY-1];
    logic [LATENCY-2:0]   pipe_v;

    always_ff @(posedge clk) begin
      if (rst || Flush) begin
        pipe_v <= '0;
      end else begin
        pipe_v[0] <= accept;
        for (int k = 1; k < LATENCY - 1; k++) pipe_v[k] <= pipe_v[k-1];
      end
      pipe[0] <= acc_entry;
      for (int k = 1; k < LATENCY - 1; k++) pipe[k] <= pipe[k-1];
    end

    assign fifo_in   = pipe[LATENCY-2];
    assign fifo_in_v = pipe_v[LATENCY-2];
  end

  always_ff @(posedge clk) begin
    if (rst || Flush) begin
      head     <= '0;
      tail     <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_in_v) begin
        fifo[tail] <= fifo_in;
        tail       <= ptr_inc(tail);
      end
      if (pop) head <= ptr_inc(head);
      fifo_cnt <= fifo_cnt + CW'(fifo_in_v) - CW'(pop);
    end
  end

  // Occupancy spans pipeline and FIFO, so bounding it keeps the FIFO from overflowing.
  always_ff @(posedge clk) begin
    if (rst || Flush) occ <= '0;
    else              occ <= occ + CW'(accept) - CW'(pop);
  end

  assign head_e   = fifo[head];
  assign RspInstr = RspValid ? head_e.instr : '0;
  assign RspAddr  = RspValid ? head_e.addr  : '0;
  assign RspFault = RspValid ? head_e.fault : 1'b0;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench for imem_fetch_responder: scoreboard of expected responses
// pushed on accept and popped on each response handshake.
module tb_imem_fetch_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        ReqValid;
  logic        ReqReady;
  logic [63:0] ReqAddr;
  logic        RspValid;
  logic        RspReady;
  logic [31:0] RspInstr;
  logic [63:0] RspAddr;
  logic        RspFault;
  logic        Flush;
  logic        LdEn;
  logic [63:0] LdAddr;
  logic [31:0] LdData;

  imem_fetch_responder dut (
    .clk(clk), .rst(rst),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqAddr(ReqAddr),
    .RspValid(RspValid), .RspReady(RspReady), .RspInstr(RspInstr),
    .RspAddr(RspAddr), .RspFault(RspFault), .Flush(Flush),
    .LdEn(LdEn), .LdAddr(LdAddr), .LdData(LdData)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] addr;
    logic        fault;
    int          acc_cyc;
    bit          exact;
  } exp_t;

  exp_t      sb[$];
  bit [31:0] mem_m [1024];
  int        n_tests = 0;
  int        n_fail  = 0;
  int        cyc     = 0;
  bit        exact_mode = 1'b0;
  int        n_acc;

  localparam logic [31:0] PROG [4] = '{32'h00500093, 32'h00a00113, 32'h002081b3, 32'h00000013};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 30) begin
      tick();
      n++;
    end
    tick();
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare each popped response, then record new accepts and loads.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
    end else begin
      if (RspValid && RspReady) begin
        if (sb.size() == 0) begin
          chk("spurious_rsp", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("rsp_instr", 64'(RspInstr), 64'(e.instr));
          chk("rsp_addr", RspAddr, e.addr);
          chk("rsp_fault", 64'(RspFault), 64'(e.fault));
          chk("latency_min", 64'(cyc - e.acc_cyc >= 2), 64'd1);
          if (e.exact) chk("latency_exact", 64'(cyc - e.acc_cyc), 64'd2);
        end
      end
      if (Flush) begin
        sb.delete();
      end else if (ReqValid && ReqReady) begin
        e.fault   = (ReqAddr[1:0] != 2'b00) || (ReqAddr[63:2] >= 62'd1024);
        e.instr   = e.fault ? 32'h0000_0013 : mem_m[ReqAddr[11:2]];
        e.addr    = ReqAddr;
        e.acc_cyc = cyc;
        e.exact   = exact_mode;
        sb.push_back(e);
      end
    end
    if (LdEn && LdAddr[63:2] < 62'd1024) mem_m[LdAddr[11:2]] = LdData;
  end

  initial begin
    rst = 1'b1; ReqValid = 1'b0; ReqAddr = '0; RspReady = 1'b0;
    Flush = 1'b0; LdEn = 1'b0; LdAddr = '0; LdData = '0;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_rspvalid", 64'(RspValid), 64'd0);
    chk("rst_rspinstr", 64'(RspInstr), 64'd0);
    chk("rst_rspaddr", RspAddr, 64'd0);
    chk("rst_rspfault", 64'(RspFault), 64'd0);
    chk("rst_reqready", 64'(ReqReady), 64'd0);
    tick();
    rst = 1'b0;

    // program load, plus an out-of-range load that must not alias word 0
    for (int i = 0; i < 4; i++) begin
      LdEn = 1'b1; LdAddr = 64'(i * 4); LdData = PROG[i];
      tick();
    end
    LdAddr = 64'd4096; LdData = 32'hbadbad00;
    tick();
    LdEn = 1'b0;

    // back-to-back fetch, no stalls
    RspReady = 1'b1; exact_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ReqValid = 1'b1; ReqAddr = 64'(i * 4);
      tick();
    end
    ReqValid = 1'b0;
    drain("drain_b2b");

    // fill under backpressure
    RspReady = 1'b0; exact_mode = 1'b0; ReqValid = 1'b1; n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      ReqAddr = 64'(n_acc * 4);
      @(negedge clk);
      if (ReqReady) n_acc++;
      tick();
    end
    ReqValid = 1'b0;
    chk("full_accepts", 64'(n_acc), 64'd4);
    @(negedge clk);
    chk("full_ready", 64'(ReqReady), 64'd0);
    chk("stall_valid", 64'(RspValid), 64'd1);
    chk("stall_addr", RspAddr, 64'd0);
    tick();
    @(negedge clk);
    chk("stall_hold_addr", RspAddr, 64'd0);
    chk("stall_hold_instr", 64'(RspInstr), 64'h00500093);
    tick();
    RspReady = 1'b1;
    @(negedge clk);
    chk("ready_first_pop", 64'(ReqReady), 64'd0);
    tick();
    @(negedge clk);
    chk("ready_after_pop", 64'(ReqReady), 64'd1);
    tick();
    drain("drain_full");

    // misaligned and out-of-range faults, then a normal fetch
    exact_mode = 1'b1; ReqValid = 1'b1;
    ReqAddr = 64'h6;    tick();
    ReqAddr = 64'd4096; tick();
    ReqAddr = 64'h8;    tick();
    ReqValid = 1'b0;
    drain("drain_fault");

    // flush with three outstanding
    RspReady = 1'b0; exact_mode = 1'b0; ReqValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ReqAddr = 64'(i * 4);
      tick();
    end
    ReqAddr = 64'd12; Flush = 1'b1;
    @(negedge clk);
    chk("flush_ready", 64'(ReqReady), 64'd0);
    tick();
    Flush = 1'b0; ReqValid = 1'b0;
    @(negedge clk);
    chk("flush_rspvalid", 64'(RspValid), 64'd0);
    RspReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      chk("flush_quiet", 64'(RspValid), 64'd0);
    end
    tick();
    exact_mode = 1'b1; ReqValid = 1'b1; ReqAddr = 64'd12;
    tick();
    ReqValid = 1'b0;
    drain("drain_flush");

    // load colliding with accept of the same word
    ReqValid = 1'b1; ReqAddr = 64'd4;
    LdEn = 1'b1; LdAddr = 64'd4; LdData = 32'hdeadbeef;
    tick();
    LdEn = 1'b0;
    tick();
    ReqValid = 1'b0;
    drain("drain_ld");

    // reset mid-stream with two outstanding; memory must survive
    RspReady = 1'b0; exact_mode = 1'b0; ReqValid = 1'b1;
    ReqAddr = 64'd0; tick();
    ReqAddr = 64'd8; tick();
    ReqValid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", 64'(ReqReady), 64'd0);
    tick();
    @(negedge clk);
    chk("rst_mid_valid", 64'(RspValid), 64'd0);
    chk("rst_mid_ready2", 64'(ReqReady), 64'd0);
    tick();
    rst = 1'b0; RspReady = 1'b1; exact_mode = 1'b1; ReqValid = 1'b1;
    ReqAddr = 64'd0;  tick();
    ReqAddr = 64'd8;  tick();
    ReqAddr = 64'd12; tick();
    ReqValid = 1'b0;
    drain("drain_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
